// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for a MIPS subset: sequences fetch/decode/exec/mem/wb and counts retirements.
// Optional memory-request timeout is enabled by defining MC_CTRL_TIMEOUT_EN.
module mc_ctrl #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             zero,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic [3:0]       alu_op,
  output logic             alu_src,
  output logic             ext_op,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic [1:0]       reg_data_src,
  output logic [2:0]       state,
  output logic             retire,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  state_t cur, nxt;
  logic   is_add, is_sub, is_jr, is_ori, is_beq, is_sw, is_lw, is_lui, is_jal, is_bad;
  logic   req_wait;
  logic   tmo_hit;

  // A zero timeout is meaningless; reject it at elaboration.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mc_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  // Instruction class from the IR fields (IR is stable from DECODE to WB).
  always_comb begin
    is_add = (op == OP_RTYPE) && (func == FN_ADD);
    is_sub = (op == OP_RTYPE) && (func == FN_SUB);
    is_jr  = (op == OP_RTYPE) && (func == FN_JR);
    is_ori = (op == OP_ORI);
    is_beq = (op == OP_BEQ);
    is_sw  = (op == OP_SW);
    is_lw  = (op == OP_LW);
    is_lui = (op == OP_LUI);
    is_jal = (op == OP_JAL);
    is_bad = !(is_add || is_sub || is_jr || is_ori || is_beq ||
               is_sw || is_lw || is_lui || is_jal);
  end

  // A request is outstanding and unanswered this cycle.
  assign req_wait = ((cur == S_FETCH) && !imem_ack) || ((cur == S_MEM) && !dmem_ack);

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = req_wait && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Cycles spent waiting on the current request; restarts on ack, abort or state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
    end else if (req_wait && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= S_IDLE;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_cnt <= '0;
    end else if (retire) begin
      retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  assign state = cur;

  // Next state and datapath controls; everything idles low unless a state asks for it.
  always_comb begin
    nxt          = cur;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'd0;
    alu_op       = 4'd0;
    alu_src      = 1'b0;
    ext_op       = 1'b0;
    reg_we       = 1'b0;
    reg_dst      = 2'd0;
    reg_data_src = 2'd0;
    retire       = 1'b0;
    illegal      = 1'b0;
    bus_err      = 1'b0;

    unique case (cur)
      S_IDLE: nxt = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
          nxt   = S_DECODE;
        end else if (tmo_hit) begin
          bus_err = 1'b1;
        end
      end

      S_DECODE: begin
        if (is_jal) begin
          pc_we        = 1'b1;
          pc_src       = 2'd2;
          reg_we       = 1'b1;
          reg_dst      = 2'd2;
          reg_data_src = 2'd2;
          retire       = 1'b1;
          nxt          = S_FETCH;
        end else if (is_jr) begin
          pc_we  = 1'b1;
          pc_src = 2'd3;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else if (is_bad) begin
          illegal = 1'b1;
          nxt     = S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        if (is_sub || is_beq) alu_op = 4'd1;
        else if (is_ori)      alu_op = 4'd2;
        else if (is_lui)      alu_op = 4'd3;
        alu_src = is_ori || is_lui || is_sw || is_lw;
        ext_op  = is_beq || is_sw || is_lw;
        if (is_beq) begin
          pc_we  = zero;
          pc_src = 2'd1;
          retire = 1'b1;
          nxt    = S_FETCH;
        end else if (is_sw || is_lw) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        if (dmem_ack) begin
          if (is_sw) begin
            retire = 1'b1;
            nxt    = S_FETCH;
          end else begin
            nxt = S_WB;
          end
        end else if (tmo_hit) begin
          bus_err = 1'b1;
          nxt     = S_FETCH;
        end
      end

      S_WB: begin
        reg_we       = 1'b1;
        reg_dst      = (is_add || is_sub) ? 2'd0 : 2'd1;
        reg_data_src = is_lw ? 2'd1 : 2'd0;
        retire       = 1'b1;
        nxt          = S_FETCH;
      end

      default: nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: directed instruction sequences push per-cycle expected controls,
// a negedge monitor pops and compares. Timeout cases run when MC_CTRL_TIMEOUT_EN is defined.
module tb_mc_ctrl;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef struct packed {
    logic [2:0] state;
    logic       imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       alu_src, ext_op, reg_we;
    logic [1:0] reg_dst, reg_data_src;
    logic       retire, illegal, bus_err;
  } ctrl_t;

  typedef struct {
    string       nm;
    ctrl_t       e;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [5:0]  op = '0, func = '0;
  logic        zero = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
  logic [1:0]  pc_src, reg_dst, reg_data_src;
  logic [3:0]  alu_op;
  logic        alu_src, ext_op, reg_we, retire, illegal, bus_err;
  logic [2:0]  state;
  logic [31:0] retired_cnt;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_cnt = '0;
  ctrl_t       act;

  mc_ctrl #(.CNT_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .alu_op(alu_op),
    .alu_src(alu_src), .ext_op(ext_op), .reg_we(reg_we), .reg_dst(reg_dst),
    .reg_data_src(reg_data_src), .state(state), .retire(retire),
    .illegal(illegal), .bus_err(bus_err), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  assign act = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_op,
                alu_src, ext_op, reg_we, reg_dst, reg_data_src, retire, illegal, bus_err};

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      n_vec++;
      if (act !== x.e || retired_cnt !== x.cnt) begin
        n_err++;
        $display("FAIL %s: got ctrl=%h cnt=%0d, expected ctrl=%h cnt=%0d",
                 x.nm, act, retired_cnt, x.e, x.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic ctrl_t st(input logic [2:0] s);
    ctrl_t c;
    c = '0;
    c.state = s;
    return c;
  endfunction

  task automatic step(input string nm, input ctrl_t e);
    exp_t x;
    x.nm = nm; x.e = e; x.cnt = exp_cnt;
    sb.push_back(x);
    if (e.retire) exp_cnt = exp_cnt + 32'd1;
    @(posedge clk); #1;
  endtask

  task automatic fetch(input int waits, input logic [5:0] o, input logic [5:0] f);
    ctrl_t e;
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      e = st(3'd1); e.imem_req = 1'b1;
      step("fetch_wait", e);
    end
    imem_ack = 1'b1;
    e = st(3'd1); e.imem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1;
    step("fetch_ack", e);
    imem_ack = 1'b0; op = o; func = f;
  endtask

  initial begin
    ctrl_t e;
    @(posedge clk); #1;
    step("reset", st(3'd0));
    reset = 1'b0;
    step("idle", st(3'd0));

    // ori, zero-wait, with stray acks in DECODE: 1,2,3,5
    fetch(0, OP_ORI, 6'd0);
    dmem_ack = 1'b1; imem_ack = 1'b1;
    step("ori_decode_stray", st(3'd2));
    dmem_ack = 1'b0; imem_ack = 1'b0;
    e = st(3'd3); e.alu_op = 4'd2; e.alu_src = 1'b1;
    step("ori_exec", e);
    e = st(3'd5); e.reg_we = 1'b1; e.reg_dst = 2'd1; e.retire = 1'b1;
    step("ori_wb", e);

    // lw, one fetch wait, dmem ack after 3 waits
    fetch(1, OP_LW, 6'd0);
    step("lw_decode", st(3'd2));
    e = st(3'd3); e.alu_src = 1'b1; e.ext_op = 1'b1;
    step("lw_exec", e);
    e = st(3'd4); e.dmem_req = 1'b1;
    for (int i = 0; i < 3; i++) step("lw_mem_wait", e);
    dmem_ack = 1'b1;
    step("lw_mem_ack", e);
    dmem_ack = 1'b0;
    e = st(3'd5); e.reg_we = 1'b1; e.reg_dst = 2'd1; e.reg_data_src = 2'd1; e.retire = 1'b1;
    step("lw_wb", e);

    // sw zero-wait
    fetch(0, OP_SW, 6'd0);
    step("sw_decode", st(3'd2));
    e = st(3'd3); e.alu_src = 1'b1; e.ext_op = 1'b1;
    step("sw_exec", e);
    dmem_ack = 1'b1;
    e = st(3'd4); e.dmem_req = 1'b1; e.dmem_we = 1'b1; e.retire = 1'b1;
    step("sw_mem_ack", e);
    dmem_ack = 1'b0;

    // beq taken and not taken
    fetch(0, OP_BEQ, 6'd0);
    step("beq1_decode", st(3'd2));
    zero = 1'b1;
    e = st(3'd3); e.alu_op = 4'd1; e.ext_op = 1'b1; e.pc_we = 1'b1; e.pc_src = 2'd1; e.retire = 1'b1;
    step("beq_taken", e);
    zero = 1'b0;
    fetch(0, OP_BEQ, 6'd0);
    step("beq0_decode", st(3'd2));
    e = st(3'd3); e.alu_op = 4'd1; e.ext_op = 1'b1; e.pc_src = 2'd1; e.retire = 1'b1;
    step("beq_not_taken", e);

    // add, sub, lui
    fetch(0, OP_R, FN_ADD);
    step("add_decode", st(3'd2));
    step("add_exec", st(3'd3));
    e = st(3'd5); e.reg_we = 1'b1; e.retire = 1'b1;
    step("add_wb", e);
    fetch(0, OP_R, FN_SUB);
    step("sub_decode", st(3'd2));
    e = st(3'd3); e.alu_op = 4'd1;
    step("sub_exec", e);
    e = st(3'd5); e.reg_we = 1'b1; e.retire = 1'b1;
    step("sub_wb", e);
    fetch(0, OP_LUI, 6'd0);
    step("lui_decode", st(3'd2));
    e = st(3'd3); e.alu_op = 4'd3; e.alu_src = 1'b1;
    step("lui_exec", e);
    e = st(3'd5); e.reg_we = 1'b1; e.reg_dst = 2'd1; e.retire = 1'b1;
    step("lui_wb", e);

    // jal, jr
    fetch(0, OP_JAL, 6'd0);
    e = st(3'd2); e.pc_we = 1'b1; e.pc_src = 2'd2; e.reg_we = 1'b1; e.reg_dst = 2'd2;
    e.reg_data_src = 2'd2; e.retire = 1'b1;
    step("jal_decode", e);
    fetch(0, OP_R, FN_JR);
    e = st(3'd2); e.pc_we = 1'b1; e.pc_src = 2'd3; e.retire = 1'b1;
    step("jr_decode", e);

    // illegal opcode and illegal R-type func
    fetch(0, 6'b111111, 6'd0);
    e = st(3'd2); e.illegal = 1'b1;
    step("illegal_op", e);
    fetch(0, OP_R, 6'b111111);
    e = st(3'd2); e.illegal = 1'b1;
    step("illegal_func", e);

`ifdef MC_CTRL_TIMEOUT_EN
    // FETCH timeout: refetch in place
    e = st(3'd1); e.imem_req = 1'b1;
    for (int i = 0; i < 3; i++) step("fetch_tmo_wait", e);
    e.bus_err = 1'b1;
    step("fetch_tmo", e);
    // sw with no dmem ack aborts on the 4th MEM cycle
    fetch(0, OP_SW, 6'd0);
    step("swt_decode", st(3'd2));
    e = st(3'd3); e.alu_src = 1'b1; e.ext_op = 1'b1;
    step("swt_exec", e);
    e = st(3'd4); e.dmem_req = 1'b1; e.dmem_we = 1'b1;
    for (int i = 0; i < 3; i++) step("swt_mem_wait", e);
    e.bus_err = 1'b1;
    step("swt_mem_tmo", e);
`else
    // Unbounded wait: long dmem stall without abort
    fetch(0, OP_SW, 6'd0);
    step("swl_decode", st(3'd2));
    e = st(3'd3); e.alu_src = 1'b1; e.ext_op = 1'b1;
    step("swl_exec", e);
    e = st(3'd4); e.dmem_req = 1'b1; e.dmem_we = 1'b1;
    for (int i = 0; i < 8; i++) step("swl_mem_wait", e);
    dmem_ack = 1'b1; e.retire = 1'b1;
    step("swl_mem_ack", e);
    dmem_ack = 1'b0;
`endif

    // reset mid-MEM drops everything within the cycle
    fetch(0, OP_LW, 6'd0);
    step("lwr_decode", st(3'd2));
    e = st(3'd3); e.alu_src = 1'b1; e.ext_op = 1'b1;
    step("lwr_exec", e);
    e = st(3'd4); e.dmem_req = 1'b1;
    step("lwr_mem_wait", e);
    reset = 1'b1;
    exp_cnt = '0;
    step("reset_mid_mem", st(3'd0));
    reset = 1'b0;
    step("idle_after_reset", st(3'd0));

    // recovery: ori retires and count restarts from 0
    fetch(0, OP_ORI, 6'd0);
    step("ori2_decode", st(3'd2));
    e = st(3'd3); e.alu_op = 4'd2; e.alu_src = 1'b1;
    step("ori2_exec", e);
    e = st(3'd5); e.reg_we = 1'b1; e.reg_dst = 2'd1; e.retire = 1'b1;
    step("ori2_wb", e);
    e = st(3'd1); e.imem_req = 1'b1;
    step("final_fetch", e);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
